decode_frame_sequencer: RTL

Synthesizable host-side protocol engine sitting between a syndrome byte source and the decoder's byte-wide input/output FIFOs. It replaces bench-only loading logic with RTL:
- issues the start-decoding message once per session;
- frames each measurement payload with a header;
- parses the decoder's result message into iteration and cycle fields;
- reports one tagged result record per frame, with a watchdog timeout for a non-responding decoder.

---
 rtl/decode_frame_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/decode_frame_sequencer.sv
// Host-side engine between a syndrome byte source and the decoder FIFOs: sends the
// start opcode once per session, frames each payload, and reports one tagged result per frame.
module decode_frame_sequencer #(
  parameter int         BYTES_PER_FRAME   = 10,
  parameter int         RESULT_BYTES      = 3,
  parameter logic [7:0] START_MSG         = 8'h01,
  parameter logic [7:0] HEADER_MSG        = 8'h02,
  parameter int         TIMEOUT_CYCLES    = 65535,
  parameter int         FRAME_COUNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [7:0]                   syn_data,
  input  logic                         syn_valid,
  output logic                         syn_ready,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic                         rx_ready,
  output logic [7:0]                   res_iterations,
  output logic [15:0]                  res_cycles,
  output logic [FRAME_COUNT_WIDTH-1:0] res_frame,
  output logic                         res_timeout,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic                         busy
);

  localparam int BC_W  = $clog2(BYTES_PER_FRAME + 1);
  localparam int RX_W  = $clog2(RESULT_BYTES + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BC_W-1:0]  LAST_BYTE  = BC_W'(BYTES_PER_FRAME - 1);
  localparam logic [RX_W-1:0]  LAST_RX    = RX_W'(RESULT_BYTES - 1);
  localparam logic [TMR_W-1:0] LAST_TICK  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMER_SAT  = TMR_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_HEADER,
    S_PAYLOAD,
    S_WAIT_RESULT,
    S_RECV,
    S_REPORT
  } state_e;

  state_e                       state_q,    state_d;
  logic [BC_W-1:0]              byte_cnt_q, byte_cnt_d;
  logic [RX_W-1:0]              rx_idx_q,   rx_idx_d;
  logic [TMR_W-1:0]             timer_q,    timer_d;
  logic [7:0]                   iter_q,     iter_d;
  logic [15:0]                  cycles_q,   cycles_d;
  logic [FRAME_COUNT_WIDTH-1:0] frame_q,    frame_d;
  logic                         timeout_q,  timeout_d;

  logic tx_hs;
  logic rx_hs;
  logic rx_done;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      rx_idx_q   <= '0;
      timer_q    <= '0;
      iter_q     <= '0;
      cycles_q   <= '0;
      frame_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      rx_idx_q   <= rx_idx_d;
      timer_q    <= timer_d;
      iter_q     <= iter_d;
      cycles_q   <= cycles_d;
      frame_q    <= frame_d;
      timeout_q  <= timeout_d;
    end
  end

  // NOTE: every output is given a default before the case so no path can infer a latch.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    syn_ready = 1'b0;
    // The result drain is open everywhere except REPORT, but held low while reset is asserted.
    rx_ready  = ~reset;
    res_valid = 1'b0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_START: begin
        tx_valid = 1'b1;
        tx_data  = START_MSG;
      end
      S_HEADER: begin
        tx_valid = 1'b1;
        tx_data  = HEADER_MSG;
      end
      S_PAYLOAD: begin
        tx_valid  = syn_valid;
        tx_data   = syn_data;
        syn_ready = tx_ready;
      end
      S_REPORT: begin
        rx_ready  = 1'b0;
        res_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign tx_hs   = tx_valid & tx_ready;
  assign rx_hs   = rx_valid & rx_ready;
  assign rx_done = rx_hs && (rx_idx_q == LAST_RX);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    rx_idx_d   = rx_idx_q;
    timer_d    = timer_q;
    iter_d     = iter_q;
    cycles_d   = cycles_q;
    frame_d    = frame_q;
    timeout_d  = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_START;
      end

      S_START: begin
        if (tx_hs) state_d = S_HEADER;
      end

      S_HEADER: begin
        if (tx_hs) begin
          state_d    = S_PAYLOAD;
          byte_cnt_d = '0;
        end
      end

      S_PAYLOAD: begin
        if (tx_hs) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == LAST_BYTE) begin
            state_d  = S_WAIT_RESULT;
            timer_d  = '0;
            rx_idx_d = '0;
          end
        end
      end

      S_WAIT_RESULT, S_RECV: begin
        if (timer_q != TIMER_SAT) timer_d = timer_q + 1'b1;

        if (rx_hs) begin
          state_d  = S_RECV;
          rx_idx_d = rx_idx_q + 1'b1;
          case (rx_idx_q)
            RX_W'(0): iter_d         = rx_data;
            RX_W'(1): cycles_d[15:8] = rx_data;
            RX_W'(2): cycles_d[7:0]  = rx_data;
            default: ;
          endcase
        end

        // A final byte landing on the last watchdog tick still counts as a real result.
        if (rx_done) begin
          state_d   = S_REPORT;
          timeout_d = 1'b0;
        end else if (timer_q == LAST_TICK) begin
          state_d   = S_REPORT;
          timeout_d = 1'b1;
          iter_d    = 8'h00;
          cycles_d  = 16'h0000;
        end
      end

      S_REPORT: begin
        if (res_ready) begin
          frame_d = frame_q + 1'b1;
          state_d = enable ? S_HEADER : S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign res_iterations = iter_q;
  assign res_cycles     = cycles_q;
  assign res_frame      = frame_q;
  assign res_timeout    = timeout_q;

endmodule
